ram_port_arbiter: RTL

//  Two-requester arbiter/sequencer for the SRAM-style port of Ram2Ddr (ram_a/ram_dq_i/ram_dq_o/cen/oen/wen).

---
 rtl/ram_port_arbiter_if.sv | 36 +++
 rtl/ram_port_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter_if.sv
// Requester and Ram2Ddr SRAM-port signal bundle for ram_port_arbiter.
// slave = arbiter view, master = surrounding datapath / memory view.
interface ram_port_arbiter_if #(
   parameter int unsigned ADDR_W = 27,
   parameter int unsigned DATA_W = 32
);
   logic              a_req;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic              a_ack;
   logic [DATA_W-1:0] a_rdata;
   logic              b_req;
   logic              b_we;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_wdata;
   logic              b_ack;
   logic [DATA_W-1:0] b_rdata;
   logic              busy;
   logic [ADDR_W-1:0] ram_a;
   logic [DATA_W-1:0] ram_dq_i;
   logic [DATA_W-1:0] ram_dq_o;
   logic              ram_cen;
   logic              ram_oen;
   logic              ram_wen;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, ram_dq_o,
      output a_ack, a_rdata, b_ack, b_rdata, busy, ram_a, ram_dq_i, ram_cen, ram_oen, ram_wen
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, ram_dq_o,
      input  a_ack, a_rdata, b_ack, b_rdata, busy, ram_a, ram_dq_i, ram_cen, ram_oen, ram_wen
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin two-port sequencer for the Ram2Ddr SRAM-style port: fixed-length
// accesses with setup and recovery phases, all outputs registered.
module ram_port_arbiter #(
   parameter int unsigned ADDR_W          = 27,
   parameter int unsigned DATA_W          = 32,
   parameter int unsigned ACCESS_CYCLES   = 27,
   parameter int unsigned RECOVERY_CYCLES = 2
) (
   input  logic               clk_100MHz,
   input  logic               rstn,
   ram_port_arbiter_if.slave  bus
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_SETUP   = 2'd1;
   localparam logic [1:0] S_ACCESS  = 2'd2;
   localparam logic [1:0] S_RECOVER = 2'd3;

   localparam logic [7:0] ACC_LOAD = 8'(ACCESS_CYCLES - 1);
   localparam logic [7:0] REC_LOAD = 8'(RECOVERY_CYCLES - 1);

   logic [1:0]        state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              last_b_q, last_b_d;
   logic              gnt_b_q, gnt_b_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              cen_q, cen_d;
   logic              oen_q, oen_d;
   logic              wen_q, wen_d;
   logic              a_ack_q, a_ack_d;
   logic              b_ack_q, b_ack_d;
   logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
   logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
   logic              busy_q, busy_d;
   logic              pick_b;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_b_d  = last_b_q;
      gnt_b_d   = gnt_b_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      cen_d     = 1'b1;
      oen_d     = 1'b1;
      wen_d     = 1'b1;
      a_ack_d   = 1'b0;
      b_ack_d   = 1'b0;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      // On a tie, B wins only if A was granted last.
      pick_b    = bus.b_req && (!bus.a_req || !last_b_q);

      case (state_q)
         S_IDLE: begin
            if (bus.a_req || bus.b_req) begin
               gnt_b_d  = pick_b;
               last_b_d = pick_b;
               we_d     = pick_b ? bus.b_we    : bus.a_we;
               addr_d   = pick_b ? bus.b_addr  : bus.a_addr;
               wdata_d  = pick_b ? bus.b_wdata : bus.a_wdata;
               state_d  = S_SETUP;
            end
         end
         S_SETUP: begin
            cen_d   = 1'b0;
            oen_d   = we_q;
            wen_d   = !we_q;
            cnt_d   = ACC_LOAD;
            state_d = S_ACCESS;
         end
         S_ACCESS: begin
            if (cnt_q == '0) begin
               cnt_d   = REC_LOAD;
               state_d = S_RECOVER;
               a_ack_d = !gnt_b_q;
               b_ack_d = gnt_b_q;
               if (!we_q && !gnt_b_q) a_rdata_d = bus.ram_dq_o;
               if (!we_q &&  gnt_b_q) b_rdata_d = bus.ram_dq_o;
            end else begin
               cnt_d = cnt_q - 8'd1;
               cen_d = 1'b0;
               oen_d = we_q;
               wen_d = !we_q;
            end
         end
         default: begin
            if (cnt_q == '0) state_d = S_IDLE;
            else             cnt_d   = cnt_q - 8'd1;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_100MHz or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         last_b_q  <= 1'b1;
         gnt_b_q   <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cen_q     <= 1'b1;
         oen_q     <= 1'b1;
         wen_q     <= 1'b1;
         a_ack_q   <= 1'b0;
         b_ack_q   <= 1'b0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_b_q  <= last_b_d;
         gnt_b_q   <= gnt_b_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         cen_q     <= cen_d;
         oen_q     <= oen_d;
         wen_q     <= wen_d;
         a_ack_q   <= a_ack_d;
         b_ack_q   <= b_ack_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.ram_a    = addr_q;
   assign bus.ram_dq_i = wdata_q;
   assign bus.ram_cen  = cen_q;
   assign bus.ram_oen  = oen_q;
   assign bus.ram_wen  = wen_q;
   assign bus.a_ack    = a_ack_q;
   assign bus.b_ack    = b_ack_q;
   assign bus.a_rdata  = a_rdata_q;
   assign bus.b_rdata  = b_rdata_q;
   assign bus.busy     = busy_q;

endmodule
